// File: rtl/ram_byte_en.sv
// Byte-strobed single-clock RAM with a pipelined read port and a zero-fill engine.
// Optional macro RAM_WR_BYPASS_EN forwards same-cycle write lanes into a same-address read.
module ram_byte_en #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int ADDR_WIDTH   = 12,
  parameter int READ_LATENCY = 1,
  parameter     TYPE         = "block"
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               s_read_req,
  input  logic [ADDR_WIDTH-1:0]              s_read_addr,
  output logic [DATA_WIDTH-1:0]              s_read_data,
  output logic                               s_read_valid,
  input  logic                               s_write_req,
  input  logic [ADDR_WIDTH-1:0]              s_write_addr,
  input  logic [DATA_WIDTH-1:0]              s_write_data,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]   s_write_strb,
  input  logic                               clear_req,
  output logic                               clear_busy
);

  localparam int LANES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic {IDLE, CLEAR} state_t;

  (* ram_style = TYPE *) logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t                  state, state_nx;
  logic [ADDR_WIDTH-1:0]   cnt;
  logic                    cnt_last;
  logic                    rd_acc;
  logic                    wr_acc;
  logic [DATA_WIDTH-1:0]   rd_word;

  assign clear_busy = (state == CLEAR);
  assign cnt_last   = (cnt == {ADDR_WIDTH{1'b1}});
  // Requests are ignored during reset and while the zero-fill owns the array.
  assign rd_acc     = s_read_req  && !clear_busy && !reset;
  assign wr_acc     = s_write_req && !clear_busy && !reset;

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (clear_req) state_nx = CLEAR;
      CLEAR:   if (cnt_last)  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE) begin
        if (clear_req) cnt <= '0;
      end else if (!cnt_last) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (clear_busy) begin
        mem[cnt] <= '0;
      end else if (wr_acc) begin
        for (int b = 0; b < LANES; b++) begin
          if (s_write_strb[b]) mem[s_write_addr][b*BYTE_WIDTH +: BYTE_WIDTH] <= s_write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

`ifdef RAM_WR_BYPASS_EN
  always_comb begin
    rd_word = mem[s_read_addr];
    if (wr_acc && (s_write_addr == s_read_addr)) begin
      for (int b = 0; b < LANES; b++) begin
        if (s_write_strb[b]) rd_word[b*BYTE_WIDTH +: BYTE_WIDTH] = s_write_data[b*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end
`else
  assign rd_word = mem[s_read_addr];
`endif

  // Read pipeline: stage i holds a word accepted i+1 cycles ago; the last stage
  // is the output register and only loads on a valid word so it holds its value.
  for (genvar i = 0; i < READ_LATENCY; i++) begin : g_stage
    logic                  vld;
    logic [DATA_WIDTH-1:0] data;
    logic                  vld_in;
    logic [DATA_WIDTH-1:0] data_in;

    if (i == 0) begin : g_first
      assign vld_in  = rd_acc;
      assign data_in = rd_word;
    end else begin : g_next
      assign vld_in  = g_stage[i-1].vld;
      assign data_in = g_stage[i-1].data;
    end

    always_ff @(posedge clk) begin
      if (reset) vld <= 1'b0;
      else       vld <= vld_in;
    end

    if (i == READ_LATENCY - 1) begin : g_out
      always_ff @(posedge clk) begin
        if (reset)       data <= '0;
        else if (vld_in) data <= data_in;
      end
    end else begin : g_mid
      always_ff @(posedge clk) begin
        data <= data_in;
      end
    end
  end

  assign s_read_valid = g_stage[READ_LATENCY-1].vld;
  assign s_read_data  = g_stage[READ_LATENCY-1].data;

endmodule

// File: tb/tb_ram_byte_en.sv
// Self-checking bench for ram_byte_en (32-bit words, 16 entries, read latency 2).
module tb_ram_byte_en;

  logic        clk = 1'b0;
  logic        reset;
  logic        s_read_req;
  logic [3:0]  s_read_addr;
  logic [31:0] s_read_data;
  logic        s_read_valid;
  logic        s_write_req;
  logic [3:0]  s_write_addr;
  logic [31:0] s_write_data;
  logic [3:0]  s_write_strb;
  logic        clear_req;
  logic        clear_busy;

  ram_byte_en #(
    .DATA_WIDTH(32), .BYTE_WIDTH(8), .ADDR_WIDTH(4), .READ_LATENCY(2), .TYPE("block")
  ) dut (
    .clk(clk), .reset(reset),
    .s_read_req(s_read_req), .s_read_addr(s_read_addr),
    .s_read_data(s_read_data), .s_read_valid(s_read_valid),
    .s_write_req(s_write_req), .s_write_addr(s_write_addr),
    .s_write_data(s_write_data), .s_write_strb(s_write_strb),
    .clear_req(clear_req), .clear_busy(clear_busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [3:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[6];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    if (sb.size() > 0 && sb[0].due < cyc) begin
      e = sb.pop_front();
      checks++;
      errors++;
      $display("FAIL rd_missing: no valid by cycle %0d, want data %h at cycle %0d", cyc, e.data, e.due);
    end
    if (s_read_valid === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL rd_unexpected: got valid with data %h, want no valid (cycle %0d)", s_read_data, cyc);
      end else begin
        e = sb.pop_front();
        check("rd_data", s_read_data, e.data);
        check("rd_time", 32'(cyc), 32'(e.due));
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    monitor();
  endtask

  task automatic idle_inputs();
    s_read_req  = 1'b0;
    s_write_req = 1'b0;
    clear_req   = 1'b0;
    s_write_strb = '0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    s_write_req = 1'b1; s_write_addr = a; s_write_data = d; s_write_strb = s;
    cycle();
    idle_inputs();
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp);
    s_read_req = 1'b1; s_read_addr = a;
    sb.push_back('{exp, cyc + 2});
    cycle();
    idle_inputs();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_cnt;
    vecs[0] = '{4'd3, 32'hAABBCCDD, 4'hF, 32'hAABBCCDD};
    vecs[1] = '{4'd3, 32'h11223344, 4'h5, 32'hAA22CC44};
    vecs[2] = '{4'd7, 32'h01020304, 4'hF, 32'h01020304};
    vecs[3] = '{4'd7, 32'hFFFFFFFF, 4'h0, 32'h01020304};
    vecs[4] = '{4'd7, 32'hA5A5A5A5, 4'h8, 32'hA5020304};
    vecs[5] = '{4'd7, 32'h5A5A5A5A, 4'h2, 32'hA5025A04};

    idle_inputs();
    s_read_addr = '0; s_write_addr = '0; s_write_data = '0;
    reset = 1'b1;
    repeat (3) cycle();
    check("rst_busy", 32'(clear_busy), 32'd0);
    check("rst_valid", 32'(s_read_valid), 32'd0);
    check("rst_data", s_read_data, 32'd0);
    reset = 1'b0;
    cycle();

    // Strobed writes, each followed by a read-back.
    for (int i = 0; i < 6; i++) begin
      do_write(vecs[i].addr, vecs[i].wdata, vecs[i].strb);
      do_read(vecs[i].addr, vecs[i].exp);
    end
    repeat (3) cycle();

    // Back-to-back reads, then the output holds the last word.
    do_write(4'd0, 32'h00000100, 4'hF);
    do_write(4'd1, 32'h00000201, 4'hF);
    do_write(4'd2, 32'h00000302, 4'hF);
    do_read(4'd0, 32'h00000100);
    do_read(4'd1, 32'h00000201);
    do_read(4'd2, 32'h00000302);
    repeat (4) cycle();
    check("hold_data", s_read_data, 32'h00000302);

    // Same-cycle read and write to one address.
    do_write(4'd5, 32'h0000FFFF, 4'hF);
    s_read_req = 1'b1; s_read_addr = 4'd5;
    s_write_req = 1'b1; s_write_addr = 4'd5; s_write_data = 32'h12345678; s_write_strb = 4'hC;
`ifdef RAM_WR_BYPASS_EN
    sb.push_back('{32'h1234FFFF, cyc + 2});
`else
    sb.push_back('{32'h0000FFFF, cyc + 2});
`endif
    cycle();
    idle_inputs();
    do_read(4'd5, 32'h1234FFFF);
    repeat (3) cycle();

    // Full zero-fill with dropped requests and a repeated clear_req mid-fill.
    for (int a = 0; a < 16; a++) do_write(4'(a), 32'hFFFFFFFF, 4'hF);
    clear_req = 1'b1;
    cycle();
    idle_inputs();
    busy_cnt = 0;
    for (int i = 0; i < 40 && clear_busy === 1'b1; i++) begin
      busy_cnt++;
      if (i == 10) begin
        s_write_req = 1'b1; s_write_addr = 4'd2; s_write_data = 32'h12345678; s_write_strb = 4'hF;
        s_read_req = 1'b1; s_read_addr = 4'd2;
        clear_req = 1'b1;
      end
      cycle();
      idle_inputs();
    end
    check("clear_busy_len", 32'(busy_cnt), 32'd16);
    for (int a = 0; a < 16; a++) do_read(4'(a), 32'h0);
    repeat (4) cycle();

    // Reset partway through a fill; a read issued with clear_req still completes.
    do_write(4'd2, 32'hDEAD0002, 4'hF);
    do_write(4'd10, 32'hCAFE000A, 4'hF);
    s_read_req = 1'b1; s_read_addr = 4'd10;
    sb.push_back('{32'hCAFE000A, cyc + 2});
    clear_req = 1'b1;
    cycle();
    idle_inputs();
    check("clear_started", 32'(clear_busy), 32'd1);
    repeat (4) cycle();
    reset = 1'b1;
    s_write_req = 1'b1; s_write_addr = 4'd10; s_write_data = 32'h0; s_write_strb = 4'hF;
    s_read_req = 1'b1; s_read_addr = 4'd10;
    cycle();
    idle_inputs();
    check("midreset_busy", 32'(clear_busy), 32'd0);
    check("midreset_valid", 32'(s_read_valid), 32'd0);
    check("midreset_data", s_read_data, 32'd0);
    reset = 1'b0;
    do_read(4'd2, 32'h0);
    do_read(4'd10, 32'hCAFE000A);
    repeat (4) cycle();

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
